// File: rtl/ctx_fetch_arbiter.sv
// Fetch-stage arbiter between program memory and timer-injected instructions.
// Freezes the PC around injected sequences and commits context-branch (bctx) switches.
module ctx_fetch_arbiter #(
   parameter logic [31:0] NOP_INSTR = 32'hA000_0000,
   parameter logic [5:0]  OP_BCTX   = 6'b111111,
   parameter int unsigned INJ_MAX   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flag_pausa,
   input  logic [31:0] instr_timer,
   input  logic [31:0] instr_mem,
   input  logic [31:0] end_pc,
   input  logic [31:0] reg_a_data,
   input  logic [31:0] reg_b_data,
   output logic [31:0] instrucao,
   output logic        pc_hold,
   output logic        pc_load,
   output logic [31:0] pc_next,
   output logic [31:0] contexto,
   output logic [31:0] saved_pc,
   output logic        switch_done,
   output logic        inj_abort
);

   localparam int unsigned CNT_W = $clog2(INJ_MAX + 1);
   localparam logic [CNT_W-1:0] INJ_LAST = CNT_W'(INJ_MAX - 1);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_INJECT,
      ST_SWITCH,
      ST_WAIT,
      ST_RESUME
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] inj_cnt;
   logic             bctx_mem;
   logic             bctx_timer;

   assign bctx_mem   = (instr_mem[31:26] == OP_BCTX);
   assign bctx_timer = (instr_timer[31:26] == OP_BCTX);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      instrucao = instr_mem;
      pc_hold   = 1'b0;
      case (state)
         ST_RUN: begin
            instrucao = instr_mem;
            pc_hold   = 1'b0;
         end
         ST_INJECT: begin
            instrucao = instr_timer;
            pc_hold   = 1'b1;
         end
         default: begin
            instrucao = NOP_INSTR;
            pc_hold   = 1'b1;
         end
      endcase
   end

   // NOTE: all state and registered outputs use non-blocking assignments.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_RUN;
         inj_cnt     <= '0;
         contexto    <= '0;
         saved_pc    <= '0;
         pc_next     <= '0;
         pc_load     <= 1'b0;
         switch_done <= 1'b0;
         inj_abort   <= 1'b0;
      end else begin
         // pc_load and switch_done are single-cycle strobes unless re-armed below.
         pc_load     <= 1'b0;
         switch_done <= 1'b0;
         case (state)
            ST_RUN: begin
               if (flag_pausa) begin
                  saved_pc <= end_pc;
                  inj_cnt  <= '0;
                  state    <= ST_INJECT;
               end else if (bctx_mem) begin
                  pc_next  <= reg_a_data;
                  contexto <= reg_b_data;
                  pc_load  <= 1'b1;
                  state    <= ST_SWITCH;
               end
            end
            ST_INJECT: begin
               inj_cnt <= inj_cnt + CNT_W'(1);
               if (bctx_timer) begin
                  pc_next  <= reg_a_data;
                  contexto <= reg_b_data;
                  pc_load  <= 1'b1;
                  state    <= ST_SWITCH;
               end else if (!flag_pausa) begin
                  pc_next <= saved_pc;
                  pc_load <= 1'b1;
                  state   <= ST_RESUME;
               end else if (inj_cnt == INJ_LAST) begin
                  inj_abort <= 1'b1;
                  pc_next   <= saved_pc;
                  pc_load   <= 1'b1;
                  state     <= ST_RESUME;
               end
            end
            ST_SWITCH: begin
               switch_done <= 1'b1;
               state       <= ST_WAIT;
            end
            ST_WAIT: begin
               // Timer may still be draining its sequence; hold the pipeline until it lets go.
               if (!flag_pausa) state <= ST_RUN;
            end
            ST_RESUME: begin
               state <= ST_RUN;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   a_pc_load_pulse: assert property (@(posedge clk) disable iff (reset) pc_load |=> !pc_load);
   a_abort_sticky:  assert property (@(posedge clk) disable iff (reset) inj_abort |=> inj_abort);
   a_hold_off_run:  assert property (@(posedge clk) disable iff (reset) (state != ST_RUN) |-> pc_hold);

endmodule
